fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 8, width of FIFO read data and output stream data.
REQ-002 Parameter PKT_LEN, default 4, bytes per packet; used only when FIFO_READER_PKT_EN is defined.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock shared with the FIFO.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  permits new FIFO reads when high.
REQ-007 buf_empty  input  1  FIFO empty flag.
REQ-008 buf_out  input  DATA_W  FIFO read data, valid the cycle after rd_en.
REQ-009 rd_en  output  1  FIFO read strobe, registered.
REQ-010 m_data  output  DATA_W  output stream data.
REQ-011 m_valid  output  1  m_data holds a byte.
REQ-012 m_ready  input  1  downstream accepts the byte when high with m_valid.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 rd_count  output  16  bytes delivered on the output stream.

Function
REQ-015 Internal 3-entry output buffer with occupancy occ (0..3) and in-flight count inflight (0..1).
REQ-016 rd_en is registered: next rd_en = enable & ~buf_empty & (occ + inflight + next-cycle capture) < 3 & state==RUN; no combinational path from m_ready to rd_en.
REQ-017 rd_en is never high in a cycle where buf_empty was high at the preceding edge.
REQ-018 buf_out is captured into the buffer at the clock edge ending the cycle after rd_en was high.
REQ-019 Latency: rd_en high in cycle N -> m_valid high in cycle N+2 when the buffer is empty.
REQ-020 m_valid = (occ != 0); m_data is the oldest entry.
REQ-021 Handshake: a byte transfers on each edge where m_valid & m_ready; while m_valid & ~m_ready, m_data stays stable.
REQ-022 Steady state with m_ready held high and the FIFO non-empty: one byte per cycle, no bubbles after the first.
REQ-023 Simultaneous capture and transfer in one cycle leaves occ unchanged.
REQ-024 States: IDLE, RUN, DRAIN.
REQ-025 IDLE->RUN when enable=1.
REQ-026 RUN->DRAIN when enable=0.
REQ-027 DRAIN->RUN when enable=1.
REQ-028 DRAIN->IDLE when occ=0 & inflight=0.
REQ-029 In DRAIN, no new rd_en is issued; the in-flight byte is still captured; buffered bytes are still delivered.
REQ-030 rd_count increments by 1 per transfer and wraps 16'hFFFF -> 0.

Reset
REQ-031 rst_n low immediately forces rd_en=0, m_valid=0, m_data=0, busy=0, rd_count=0, occ=0, inflight=0, state=IDLE (and m_last=0 when configured).
REQ-032 Reset mid-operation discards buffered and in-flight bytes; the FIFO read already issued is not replayed.
REQ-033 The block leaves reset synchronously on the first rising edge after rst_n goes high.

Configuration
REQ-034 Macro FIFO_READER_PKT_EN, when defined, adds output m_last (1 bit), high with m_valid on every PKT_LEN-th byte; it is driven by a byte-in-packet counter that advances only on transfers.
REQ-035 Without FIFO_READER_PKT_EN, the m_last port and the packet counter do not exist.

Structure
REQ-036 Package fifo_reader_pkg holds the state enumeration (IDLE/RUN/DRAIN), BUF_DEPTH=3 and the rd_count width constant.
REQ-037 Sub-module fifo_reader_buf implements the 3-entry circular buffer: push, pop, occ, head data.

Verification
REQ-038 FIFO preloaded with 18,9,20; enable=1, m_ready=1 -> m_data 18,9,20 on consecutive cycles; first m_valid 2 cycles after first rd_en; rd_count=3; rd_en low once buf_empty is high.
REQ-039 m_ready=0 with 5 bytes in the FIFO -> exactly 3 reads, occ=3, rd_en stays low, m_data=first byte stable; m_ready=1 -> all 5 delivered in order.
REQ-040 enable dropped with 1 byte in flight and 2 buffered -> DRAIN, 3 bytes delivered, no further rd_en, then IDLE with busy=0.
REQ-041 rst_n pulsed low with occ=2 -> m_valid=0 and rd_en=0 before the next edge, rd_count=0, state=IDLE.
REQ-042 rd_count preset by 65535 transfers, one more -> rd_count=0.
REQ-043 With FIFO_READER_PKT_EN, PKT_LEN=4, bytes 40,64,1,2,3 -> m_last high on byte 2 only; with m_ready toggled 1,0,1 the count still advances only on transfers.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader.
// Optional FIFO_READER_PKT_EN adds packet framing (m_last) in the top.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int BUF_DEPTH = 3;
    localparam int OCC_W     = 2;
    localparam int CNT_W     = 16;

    function automatic logic [OCC_W-1:0] ptr_inc(input logic [OCC_W-1:0] p);
        return (p == OCC_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry circular output buffer: push at tail, pop at head.
// Callers never push when full or pop when empty.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [OCC_W-1:0]  occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [OCC_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Reads a synchronous FIFO and streams bytes out over valid/ready.
// Define FIFO_READER_PKT_EN to add m_last every PKT_LEN-th byte.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef FIFO_READER_PKT_EN
    ,
    parameter int PKT_LEN = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_out,
    output logic              rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
`ifdef FIFO_READER_PKT_EN
    output logic              m_last,
`endif
    output logic [CNT_W-1:0]  rd_count
);

    state_t            state;
    state_t            state_n;
    logic              inflight;
    logic              pop;
    logic              rd_en_n;
    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head;
    logic [2:0]        occ_n;
    logic [2:0]        load;

    fifo_reader_buf #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .din  (buf_out),
        .pop  (pop),
        .occ  (occ),
        .head (head)
    );

    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? head : '0;
    assign pop     = m_valid & m_ready;
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = RUN;
            RUN:     if (!enable) state_n = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_n = RUN;
                end else if (occ == '0 && !inflight) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Reserve a slot for every byte already requested so the buffer never overflows.
    always_comb begin
        occ_n   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        load    = occ_n + {2'b0, rd_en};
        rd_en_n = enable & ~buf_empty & (load < 3'(BUF_DEPTH))
                & (state_n == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            state    <= state_n;
            rd_en    <= rd_en_n;
            inflight <= rd_en;
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

`ifdef FIFO_READER_PKT_EN
    localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic [PKT_W-1:0] pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (pop) begin
            pkt_cnt <= (pkt_cnt == PKT_W'(PKT_LEN - 1)) ? '0 : pkt_cnt + 1'b1;
        end
    end

    assign m_last = m_valid & (pkt_cnt == PKT_W'(PKT_LEN - 1));
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a behavioural FIFO model.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        buf_empty;
    logic [7:0]  buf_out = 8'd0;
    logic        rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        busy;
    logic [15:0] rd_count;
`ifdef FIFO_READER_PKT_EN
    logic        m_last;
`endif

    int total = 0;
    int bad = 0;

    fifo_reader #(
        .DATA_W(8)
`ifdef FIFO_READER_PKT_EN
        ,
        .PKT_LEN(4)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .buf_empty(buf_empty),
        .buf_out  (buf_out),
        .rd_en    (rd_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
`ifdef FIFO_READER_PKT_EN
        .m_last   (m_last),
`endif
        .rd_count (rd_count)
    );

    always #5 clk = ~clk;

    // FIFO model: empty flag already accounts for a read in progress
    logic [7:0] mem [0:63];
    int  wp = 0;
    int  rp = 0;
    int  reads = 0;
    int  underflow = 0;
    bit  inf_mode = 1'b0;

    assign buf_empty = inf_mode ? 1'b0 : ((wp - rp - (rd_en ? 1 : 0)) <= 0);

    always @(posedge clk) begin
        if (rd_en) begin
            reads <= reads + 1;
            if (inf_mode) begin
                buf_out <= 8'(reads);
            end else if (wp == rp) begin
                underflow <= underflow + 1;
            end else begin
                buf_out <= mem[rp % 64];
                rp <= rp + 1;
            end
        end
    end

    logic [7:0] rx[$];
    bit         rxl[$];
    int         xfers = 0;

    always @(posedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            rx.push_back(m_data);
            xfers <= xfers + 1;
`ifdef FIFO_READER_PKT_EN
            rxl.push_back(m_last);
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wp % 64] = v;
        wp++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        wp = rp;
        @(negedge clk);
        rst_n = 1'b1;
        rx.delete();
        rxl.delete();
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        e_rd;
        logic        e_v;
        logic [7:0]  e_d;
        logic [15:0] e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t tv[8];

    initial begin
        int r0;
        int x0;
        bit stable;
        bit done;
        logic [7:0] exp5[5];

        tv[0] = '{1, 1, 1, 0, 8'd0,  16'd0, 1};
        tv[1] = '{1, 1, 1, 0, 8'd0,  16'd0, 1};
        tv[2] = '{1, 1, 1, 1, 8'd18, 16'd0, 1};
        tv[3] = '{1, 1, 0, 1, 8'd9,  16'd1, 1};
        tv[4] = '{1, 1, 0, 1, 8'd20, 16'd2, 1};
        tv[5] = '{1, 1, 0, 0, 8'd0,  16'd3, 1};
        tv[6] = '{0, 1, 0, 0, 8'd0,  16'd3, 1};
        tv[7] = '{0, 1, 0, 0, 8'd0,  16'd3, 0};
        exp5 = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};

        // reset state
        #2;
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        do_reset();
        chk("rst_count", 32'(rd_count), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);

        // streaming table: 18, 9, 20
        push(8'd18);
        push(8'd9);
        push(8'd20);
        r0 = reads;
        for (int i = 0; i < 8; i++) begin
            enable = tv[i].en;
            m_ready = tv[i].rdy;
            step();
            chk($sformatf("tv%0d_rd_en", i), 32'(rd_en), 32'(tv[i].e_rd));
            chk($sformatf("tv%0d_valid", i), 32'(m_valid), 32'(tv[i].e_v));
            chk($sformatf("tv%0d_data", i), 32'(m_data), 32'(tv[i].e_d));
            chk($sformatf("tv%0d_count", i), 32'(rd_count), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
        end
        chk("tv_reads", 32'(reads - r0), 32'd3);

        // backpressure: 5 bytes, m_ready low
        do_reset();
        for (int i = 0; i < 5; i++) push(exp5[i]);
        r0 = reads;
        enable = 1'b1;
        repeat (8) step();
        chk("bp_reads", 32'(reads - r0), 32'd3);
        chk("bp_rd_en", 32'(rd_en), 32'd0);
        chk("bp_valid", 32'(m_valid), 32'd1);
        stable = 1'b1;
        repeat (3) begin
            step();
            if (m_data !== 8'd11 || rd_en !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        m_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            if (rx.size() >= 5) done = 1'b1;
        end
        chk("bp_done", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rx%0d", i),
                32'(i < rx.size() ? rx[i] : 8'hxx), 32'(exp5[i]));
        end
        enable = 1'b0;
        repeat (4) step();
        chk("bp_idle", 32'(busy), 32'd0);

        // drain: drop enable with 2 buffered and 1 in flight
        do_reset();
        for (int i = 0; i < 5; i++) push(exp5[i]);
        r0 = reads;
        enable = 1'b1;
        repeat (4) step();
        chk("dr_reads", 32'(reads - r0), 32'd3);
        enable = 1'b0;
        step();
        chk("dr_busy", 32'(busy), 32'd1);
        chk("dr_rd_en", 32'(rd_en), 32'd0);
        m_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            step();
            if (!busy) done = 1'b1;
        end
        chk("dr_to_idle", 32'(done), 32'd1);
        chk("dr_n_rx", 32'(rx.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dr_rx%0d", i),
                32'(i < rx.size() ? rx[i] : 8'hxx), 32'(exp5[i]));
        end
        chk("dr_no_more_rd", 32'(reads - r0), 32'd3);
        chk("dr_count", 32'(rd_count), 32'd3);

        // reset mid-operation with 44, 55 buffered
        m_ready = 1'b0;
        enable = 1'b1;
        repeat (4) step();
        chk("mr_valid_pre", 32'(m_valid), 32'd1);
        chk("mr_data_pre", 32'(m_data), 32'd44);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(m_valid), 32'd0);
        chk("mr_rd_en", 32'(rd_en), 32'd0);
        chk("mr_count", 32'(rd_count), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b0;
        m_ready = 1'b1;
        rx.delete();
        stable = 1'b1;
        repeat (3) begin
            step();
            if (m_valid !== 1'b0) stable = 1'b0;
        end
        chk("mr_discard", 32'(stable), 32'd1);
        chk("mr_no_rx", 32'(rx.size()), 32'd0);
        chk("underflow", 32'(underflow), 32'd0);

        // rd_count wrap
        do_reset();
        inf_mode = 1'b1;
        x0 = xfers;
        enable = 1'b1;
        m_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 70000 && !done; k++) begin
            @(negedge clk);
            if (xfers - x0 >= 65535) done = 1'b1;
            if (rx.size() > 1000) rx.delete();
        end
        m_ready = 1'b0;
        chk("wr_reached", 32'(done), 32'd1);
        chk("wr_xfers", 32'(xfers - x0), 32'd65535);
        chk("wr_ffff", 32'(rd_count), 32'hFFFF);
        @(negedge clk);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("wr_zero", 32'(rd_count), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        inf_mode = 1'b0;
        do_reset();

`ifdef FIFO_READER_PKT_EN
        // packet framing with m_ready toggling
        push(8'd40);
        push(8'd64);
        push(8'd1);
        push(8'd2);
        push(8'd3);
        enable = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            m_ready = (k % 2 == 0);
            if (rx.size() >= 5) done = 1'b1;
        end
        chk("pk_done", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pk_last%0d", i),
                32'(i < rxl.size() ? rxl[i] : 1'b1), 32'(i == 3));
        end
        chk("pk_byte3", 32'(rx.size() > 3 ? rx[3] : 8'hxx), 32'd2);
        enable = 1'b0;
        m_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
